// File: rtl/cpu_defs.sv
// Shared definitions for the fetch stage: bus widths, the NOP encoding and
// the fetch FSM state type.
package cpu_defs;

    localparam int IF_ID_W = 64;
    localparam int JBR_W   = 33;
    localparam int EXC_W   = 33;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic {
        WAIT = 1'b0,
        DONE = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/redirect_hold.sv
// One-entry redirect buffer. Remembers a taken branch (or an exception
// target) that arrived while no next_fetch pulse was present, so the
// redirect survives a pipeline stall. Exception capture always wins over a
// branch already held.
module redirect_hold (
    input  logic        clk,
    input  logic        reset,
    input  logic        next_fetch_i,
    input  logic        jbr_taken_i,
    input  logic [31:0] jbr_target_i,
    input  logic        exc_valid_i,
    input  logic [31:0] exc_pc_i,
    output logic        pend_valid_o,
    output logic [31:0] pend_target_o
);

    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    // Priority: exception, then consumption by next_fetch, then branch capture.
    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (exc_valid_i) begin
            if (next_fetch_i) begin
                // The exception target is loaded into PC directly.
                pend_valid_d = 1'b0;
            end else begin
                pend_valid_d  = 1'b1;
                pend_target_d = exc_pc_i;
            end
        end else if (next_fetch_i) begin
            // Either consumed now or superseded by a same-cycle branch.
            pend_valid_d = 1'b0;
        end else if (jbr_taken_i) begin
            pend_valid_d  = 1'b1;
            pend_target_d = jbr_target_i;
        end
    end

    // Buffer register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pend_valid_o  = pend_valid_q;
    assign pend_target_o = pend_target_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, ROM latency tracking FSM and the
// IF->ID bus. Optional misaligned-fetch detection is built when the macro
// FETCH_ALIGN_CHECK_EN is defined; otherwise fetch_adel is tied low.
//
// Handshake: next_fetch is a one-cycle pulse from pipeline control that
// advances PC on the edge where it is high; it is legal only while IF_over=1
// (if it comes early PC still advances and the latency count restarts).
// Decode samples IF_ID_bus only while IF_over=1.
module fetch_stage
    import cpu_defs::*;
#(
    parameter logic [31:0] STARTADDR = 32'h0000_0000,
    parameter int          ROM_LAT   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               IF_valid,
    input  logic               next_fetch,
    input  logic [JBR_W-1:0]   jbr_bus,
    input  logic [EXC_W-1:0]   exc_bus,
    output logic [31:0]        inst_addr,
    input  logic [31:0]        inst,
    output logic               IF_over,
    output logic [IF_ID_W-1:0] IF_ID_bus,
    output logic               fetch_adel,
    output logic [31:0]        IF_pc,
    output fetch_state_e       dbg_state,
    output logic               dbg_pend_valid
);

    localparam logic [1:0] LAT = 2'(ROM_LAT);

    logic        jbr_taken, exc_valid;
    logic [31:0] jbr_target, exc_pc;
    logic        pend_valid;
    logic [31:0] pend_target;

    logic [31:0]  pc_q, pc_d;
    fetch_state_e state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;

    assign jbr_taken  = jbr_bus[32];
    assign jbr_target = jbr_bus[31:0];
    assign exc_valid  = exc_bus[32];
    assign exc_pc     = exc_bus[31:0];

    redirect_hold u_redirect_hold (
        .clk           (clk),
        .reset         (reset),
        .next_fetch_i  (next_fetch),
        .jbr_taken_i   (jbr_taken),
        .jbr_target_i  (jbr_target),
        .exc_valid_i   (exc_valid),
        .exc_pc_i      (exc_pc),
        .pend_valid_o  (pend_valid),
        .pend_target_o (pend_target)
    );

    // Next-PC selection: exception, live branch, held redirect, sequential.
    always_comb begin
        pc_d = pc_q;
        if (next_fetch) begin
            if (exc_valid) begin
                pc_d = exc_pc;
            end else if (jbr_taken) begin
                pc_d = jbr_target;
            end else if (pend_valid) begin
                pc_d = pend_target;
            end else begin
                pc_d = pc_q + 32'd4;  // wraps silently at 2^32
            end
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= STARTADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Fetch FSM: count ROM latency cycles while the fetch is live.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!IF_valid || next_fetch) begin
            state_d = WAIT;
            cnt_d   = 2'd0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_d == LAT) begin
                state_d = DONE;
            end
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IF_over        = (state_q == DONE);
    assign inst_addr      = pc_q;
    assign IF_pc          = pc_q;
    assign dbg_state      = state_q;
    assign dbg_pend_valid = pend_valid;

`ifdef FETCH_ALIGN_CHECK_EN
    logic adel_q, adel_d;

    // Flag tracks IF_over so it is visible exactly while decode may sample.
    always_comb begin
        adel_d = (state_d == DONE) && (pc_q[1:0] != 2'b00);
    end

    // Alignment flag register, updated alongside the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            adel_q <= 1'b0;
        end else begin
            adel_q <= adel_d;
        end
    end

    assign fetch_adel = adel_q;
    assign IF_ID_bus  = {pc_q, (adel_q ? NOP : inst)};
`else
    assign fetch_adel = 1'b0;
    assign IF_ID_bus  = {pc_q, inst};
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: instance A (ROM_LAT=1) runs a vector table of
// redirect scenarios with a scoreboard queue; instance B (ROM_LAT=3) runs
// hand-written latency, IF_valid-drop, early-pulse and reset sequences.
module tb_fetch_stage;
    import cpu_defs::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_q[$];

    // ---------------- instance A, ROM_LAT = 1 ----------------
    logic         a_reset, a_valid, a_nf;
    logic [32:0]  a_jbr, a_exc;
    logic [31:0]  a_addr, a_inst, a_pc, a_d0;
    logic         a_over, a_adel, a_pend;
    logic [63:0]  a_bus;
    fetch_state_e a_state;

    fetch_stage #(.STARTADDR(32'h0), .ROM_LAT(1)) dut_a (
        .clk(clk), .reset(a_reset), .IF_valid(a_valid), .next_fetch(a_nf),
        .jbr_bus(a_jbr), .exc_bus(a_exc), .inst_addr(a_addr), .inst(a_inst),
        .IF_over(a_over), .IF_ID_bus(a_bus), .fetch_adel(a_adel), .IF_pc(a_pc),
        .dbg_state(a_state), .dbg_pend_valid(a_pend)
    );

    // ---------------- instance B, ROM_LAT = 3 ----------------
    logic         b_reset, b_valid, b_nf;
    logic [32:0]  b_jbr, b_exc;
    logic [31:0]  b_addr, b_inst, b_pc, b_d0, b_d1, b_d2;
    logic         b_over, b_adel, b_pend;
    logic [63:0]  b_bus;
    fetch_state_e b_state;

    fetch_stage #(.STARTADDR(32'h0), .ROM_LAT(3)) dut_b (
        .clk(clk), .reset(b_reset), .IF_valid(b_valid), .next_fetch(b_nf),
        .jbr_bus(b_jbr), .exc_bus(b_exc), .inst_addr(b_addr), .inst(b_inst),
        .IF_over(b_over), .IF_ID_bus(b_bus), .fetch_adel(b_adel), .IF_pc(b_pc),
        .dbg_state(b_state), .dbg_pend_valid(b_pend)
    );

    // ROM contents as a hash of the address.
    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Synchronous ROM models with 1 and 3 cycles of latency.
    always @(posedge clk) begin
        a_d0 <= rom_f(a_addr);
        b_d0 <= rom_f(b_addr);
        b_d1 <= b_d0;
        b_d2 <= b_d1;
    end
    assign a_inst = a_d0;
    assign b_inst = b_d2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic count_over_a(output int n);
        n = 0;
        while (!a_over && n < 10) begin
            tick();
            n++;
        end
    endtask

    task automatic count_over_b(output int n);
        n = 0;
        while (!b_over && n < 12) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        logic        pre_jbr;
        logic [31:0] pre_jtgt;
        logic        pre_exc;
        logic [31:0] pre_epc;
        logic        jt;
        logic [31:0] jtgt;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[14];

    task automatic run_vec(input int idx, input vec_t v);
        int          n;
        logic [31:0] exp_inst;
        logic        exp_adel;
        logic [63:0] exp_bus;
        repeat ($urandom_range(0, 2)) tick();
        if (v.pre_jbr) begin
            a_jbr = {1'b1, v.pre_jtgt};
            tick();
            a_jbr = '0;
        end
        if (v.pre_exc) begin
            a_exc = {1'b1, v.pre_epc};
            tick();
            a_exc = '0;
        end
        tick();
        check($sformatf("v%0d_pend_before", idx), a_pend, v.pre_jbr | v.pre_exc);
        a_nf  = 1'b1;
        a_jbr = {v.jt, v.jtgt};
        a_exc = {v.ev, v.epc};
        tick();
        a_nf  = 1'b0;
        a_jbr = '0;
        a_exc = '0;
        check($sformatf("v%0d_inst_addr", idx), a_addr, v.exp_pc);
        check($sformatf("v%0d_over_low", idx), a_over, 1'b0);
        check($sformatf("v%0d_pend_after", idx), a_pend, 1'b0);
        exp_inst = rom_f(v.exp_pc);
        exp_adel = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        if (v.exp_pc[1:0] != 2'b00) begin
            exp_inst = 32'h0;
            exp_adel = 1'b1;
        end
`endif
        exp_q.push_back({v.exp_pc, exp_inst});
        count_over_a(n);
        check($sformatf("v%0d_over_latency", idx), 64'(n), 64'd1);
        exp_bus = exp_q.pop_front();
        check($sformatf("v%0d_if_id_bus", idx), a_bus, exp_bus);
        check($sformatf("v%0d_fetch_adel", idx), a_adel, exp_adel);
        check($sformatf("v%0d_if_pc", idx), a_pc, v.exp_pc);
    endtask

    initial begin
        int n;
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0004};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0008};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_000C};
        vecs[3]  = '{1, 32'h40, 0, 0, 0, 0, 0, 0, 32'h0000_0040};
        vecs[4]  = '{0, 0, 0, 0, 1, 32'h40, 1, 32'h380, 32'h0000_0380};
        vecs[5]  = '{0, 0, 0, 0, 1, 32'h100, 0, 0, 32'h0000_0100};
        vecs[6]  = '{1, 32'h200, 1, 32'h300, 0, 0, 0, 0, 32'h0000_0300};
        vecs[7]  = '{1, 32'h500, 0, 0, 1, 32'h600, 0, 0, 32'h0000_0600};
        vecs[8]  = '{1, 32'h700, 0, 0, 0, 0, 1, 32'h380, 32'h0000_0380};
        vecs[9]  = '{0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000};
        vecs[11] = '{0, 0, 0, 0, 1, 32'h42, 0, 0, 32'h0000_0042};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0046};
        vecs[13] = '{0, 0, 1, 32'h1000, 0, 0, 0, 0, 32'h0000_1000};

        a_reset = 1'b1; a_valid = 1'b1; a_nf = 1'b0; a_jbr = '0; a_exc = '0;
        b_reset = 1'b1; b_valid = 1'b1; b_nf = 1'b0; b_jbr = '0; b_exc = '0;
        repeat (3) tick();

        // Reset state of instance A.
        check("rst_inst_addr", a_addr, 32'h0);
        check("rst_if_pc", a_pc, 32'h0);
        check("rst_if_over", a_over, 1'b0);
        check("rst_fetch_adel", a_adel, 1'b0);
        check("rst_bus_pc", a_bus[63:32], 32'h0);
        check("rst_pend", a_pend, 1'b0);
        check("rst_state", a_state, WAIT);

        a_reset = 1'b0;
        tick();
        check("first_if_over", a_over, 1'b1);
        check("first_bus", a_bus, {32'h0, rom_f(32'h0)});

        for (int i = 0; i < 14; i++) begin
            run_vec(i, vecs[i]);
        end
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        // Instance B: first fetch after reset takes three cycles.
        b_reset = 1'b0;
        count_over_b(n);
        check("b_first_latency", 64'(n), 64'd3);
        check("b_first_bus", b_bus, {32'h0, rom_f(32'h0)});

        // IF_valid dropped for two cycles mid-count.
        b_nf = 1'b1; tick(); b_nf = 1'b0;
        tick();
        b_valid = 1'b0;
        tick(); tick();
        check("b_drop_over_low", b_over, 1'b0);
        check("b_drop_state", b_state, WAIT);
        b_valid = 1'b1;
        count_over_b(n);
        check("b_drop_latency", 64'(n), 64'd3);
        check("b_drop_bus", b_bus, {32'h4, rom_f(32'h4)});

        // next_fetch while IF_over=0: PC advances and the count restarts.
        b_nf = 1'b1; tick(); b_nf = 1'b0;
        tick();
        b_nf = 1'b1; tick(); b_nf = 1'b0;
        check("b_early_addr", b_addr, 32'hC);
        count_over_b(n);
        check("b_early_latency", 64'(n), 64'd3);
        check("b_early_bus", b_bus, {32'hC, rom_f(32'hC)});

        // Reset mid-fetch with a redirect held.
        b_nf = 1'b1; tick(); b_nf = 1'b0;
        b_jbr = {1'b1, 32'h900}; tick(); b_jbr = '0;
        check("b_pend_set", b_pend, 1'b1);
        b_reset = 1'b1; tick(); b_reset = 1'b0;
        check("b_rst_pend", b_pend, 1'b0);
        check("b_rst_addr", b_addr, 32'h0);
        check("b_rst_over", b_over, 1'b0);
        check("b_rst_state", b_state, WAIT);
        count_over_b(n);
        check("b_rst_latency", 64'(n), 64'd3);
        b_nf = 1'b1; tick(); b_nf = 1'b0;
        check("b_rst_no_redirect", b_addr, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
